// File: rtl/mx_block_log2_max_if.sv
`default_nettype none
// ============================================================================
// Module      : mx_block_log2_max_if
// Description : Block handshake bundle for mx_block_log2_max (in and out side).
// Revision    : 1.0 - initial release
// ============================================================================
interface mx_block_log2_max_if #(
    parameter int BLOCK_SIZE = 4,
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 8
);
    localparam int LOG2_WIDTH = $clog2(MAN_WIDTH) + 1;

    logic [MAN_WIDTH-1:0]  mdata_in  [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0]  edata_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [MAN_WIDTH-1:0]  mdata_out [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0]  edata_out;
    logic [LOG2_WIDTH-1:0] log2_max_out;
    logic                  data_out_valid;
    logic                  data_out_ready;

    modport slave (
        input  mdata_in, edata_in, data_in_valid, data_out_ready,
        output data_in_ready, mdata_out, edata_out, log2_max_out, data_out_valid
    );

    modport master (
        output mdata_in, edata_in, data_in_valid, data_out_ready,
        input  data_in_ready, mdata_out, edata_out, log2_max_out, data_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mx_block_log2_max.sv
`default_nettype none
// ============================================================================
// Module      : mx_block_log2_max
// Description : Passes an MxInt block through unchanged and attaches
//               floor(log2(max |mantissa|)) of that block.
// Revision    : 1.0 - initial release
// ============================================================================
module mx_block_log2_max #(
    parameter int BLOCK_SIZE = 4,
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 8
) (
    input wire clk,
    input wire rst,
    mx_block_log2_max_if.slave bus
);
    localparam int LOG2_WIDTH = $clog2(MAN_WIDTH) + 1;
    localparam int c_LEVELS   = $clog2(BLOCK_SIZE);
    localparam int c_STAGES   = c_LEVELS + 1;
    localparam int c_PAD      = 1 << c_LEVELS;
    localparam logic [MAN_WIDTH-1:0] c_ONE = MAN_WIDTH'(1);

    // A stage may load when it or any stage ahead of it can make room.
    function automatic logic [c_STAGES-1:0] f_enables(
        input logic [c_STAGES-1:0] vld,
        input logic                pop
    );
        logic v_full;
        v_full = !pop;
        for (int s = c_STAGES - 1; s >= 0; s--) begin
            v_full       = v_full & vld[s];
            f_enables[s] = !v_full;
        end
    endfunction

    function automatic logic [LOG2_WIDTH-1:0] f_msb(input logic [MAN_WIDTH-1:0] v);
        f_msb = '0;
        for (int b = 0; b < MAN_WIDTH; b++) begin
            if (v[b]) f_msb = LOG2_WIDTH'(b);
        end
    endfunction

    logic [c_STAGES-1:0]   r_max_vld;
    logic [c_STAGES-1:0]   r_buf_vld;
    logic [c_STAGES-1:0]   w_max_en;
    logic [c_STAGES-1:0]   w_buf_en;
    logic [c_STAGES-1:0]   w_max_vin;
    logic [c_STAGES-1:0]   w_buf_vin;
    logic                  w_max_ready;
    logic                  w_buf_ready;
    logic                  w_in_fire;
    logic                  w_out_valid;
    logic                  w_pop;
    logic [MAN_WIDTH-1:0]  w_abs [BLOCK_SIZE];
    logic [MAN_WIDTH-1:0]  w_tree_max;
    logic [LOG2_WIDTH-1:0] r_log2;
    logic [MAN_WIDTH-1:0]  r_man [c_STAGES][BLOCK_SIZE];
    logic [EXP_WIDTH-1:0]  r_exp [c_STAGES];

    // Join: both branch heads must be present before the block is offered.
    assign w_out_valid = r_max_vld[c_STAGES-1] & r_buf_vld[c_STAGES-1];
    assign w_pop       = w_out_valid & bus.data_out_ready;
    assign w_max_en    = f_enables(r_max_vld, w_pop);
    assign w_buf_en    = f_enables(r_buf_vld, w_pop);

    // Split: the block enters both branches together or not at all.
    assign w_max_ready       = w_max_en[0];
    assign w_buf_ready       = w_buf_en[0];
    assign bus.data_in_ready = w_max_ready & w_buf_ready;
    assign w_in_fire         = bus.data_in_valid & bus.data_in_ready;

    always_comb begin
        w_max_vin    = '0;
        w_buf_vin    = '0;
        w_max_vin[0] = w_in_fire;
        w_buf_vin[0] = w_in_fire;
        for (int s = 1; s < c_STAGES; s++) begin
            w_max_vin[s] = r_max_vld[s-1];
            w_buf_vin[s] = r_buf_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_max_vld <= '0;
            r_buf_vld <= '0;
        end else begin
            r_max_vld <= (w_max_en & w_max_vin) | (~w_max_en & r_max_vld);
            r_buf_vld <= (w_buf_en & w_buf_vin) | (~w_buf_en & r_buf_vld);
        end
    end

    // The most negative mantissa maps to 2^(MAN_WIDTH-1) as an unsigned value.
    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_abs[i] = bus.mdata_in[i][MAN_WIDTH-1] ? (~bus.mdata_in[i] + c_ONE)
                                                    : bus.mdata_in[i];
        end
    end

    if (c_LEVELS > 0) begin : g_tree
        localparam int c_HALF = c_PAD / 2;

        logic [MAN_WIDTH-1:0] w_pad [c_PAD];
        logic [MAN_WIDTH-1:0] w_nxt [c_LEVELS][c_HALF];
        logic [MAN_WIDTH-1:0] r_max [c_LEVELS][c_HALF];

        // Zero padding to a power of two makes an odd element pass through max().
        for (genvar i = 0; i < c_PAD; i++) begin : g_pad
            if (i < BLOCK_SIZE) begin : g_elem
                assign w_pad[i] = w_abs[i];
            end else begin : g_zero
                assign w_pad[i] = '0;
            end
        end

        for (genvar k = 0; k < c_LEVELS; k++) begin : g_lvl
            for (genvar i = 0; i < c_HALF; i++) begin : g_node
                if (i < (c_PAD >> (k + 1))) begin : g_pair
                    if (k == 0) begin : g_leaf
                        assign w_nxt[k][i] = (w_pad[2*i] > w_pad[2*i+1]) ? w_pad[2*i]
                                                                         : w_pad[2*i+1];
                    end else begin : g_inner
                        assign w_nxt[k][i] = (r_max[k-1][2*i] > r_max[k-1][2*i+1])
                                           ? r_max[k-1][2*i] : r_max[k-1][2*i+1];
                    end
                end else begin : g_idle
                    assign w_nxt[k][i] = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < c_LEVELS; k++) begin
                    for (int i = 0; i < c_HALF; i++) begin
                        r_max[k][i] <= '0;
                    end
                end
            end else begin
                for (int k = 0; k < c_LEVELS; k++) begin
                    if (w_max_en[k]) r_max[k] <= w_nxt[k];
                end
            end
        end

        assign w_tree_max = r_max[c_LEVELS-1][0];
    end else begin : g_no_tree
        assign w_tree_max = w_abs[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_log2 <= '0;
        end else if (w_max_en[c_STAGES-1]) begin
            r_log2 <= f_msb(w_tree_max);
        end
    end

    // Delay line moves under its own enables, mirroring the max branch stage for stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < c_STAGES; s++) begin
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    r_man[s][i] <= '0;
                end
                r_exp[s] <= '0;
            end
        end else begin
            if (w_buf_en[0]) begin
                r_man[0] <= bus.mdata_in;
                r_exp[0] <= bus.edata_in;
            end
            for (int s = 1; s < c_STAGES; s++) begin
                if (w_buf_en[s]) begin
                    r_man[s] <= r_man[s-1];
                    r_exp[s] <= r_exp[s-1];
                end
            end
        end
    end

    assign bus.mdata_out      = r_man[c_STAGES-1];
    assign bus.edata_out      = r_exp[c_STAGES-1];
    assign bus.log2_max_out   = r_log2;
    assign bus.data_out_valid = w_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mx_block_log2_max.sv
`default_nettype none
// ============================================================================
// Module      : tb_mx_block_log2_max
// Description : Directed bench for mx_block_log2_max (BLOCK_SIZE 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mx_block_log2_max;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mx_block_log2_max_if #(.BLOCK_SIZE(4), .MAN_WIDTH(8), .EXP_WIDTH(8)) if4 ();
    mx_block_log2_max_if #(.BLOCK_SIZE(1), .MAN_WIDTH(8), .EXP_WIDTH(8)) if1 ();

    mx_block_log2_max #(.BLOCK_SIZE(4), .MAN_WIDTH(8), .EXP_WIDTH(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    mx_block_log2_max #(.BLOCK_SIZE(1), .MAN_WIDTH(8), .EXP_WIDTH(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic [31:0] blk [8];
    logic [7:0]  ex  [8];
    logic [3:0]  lg  [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set4(input logic [31:0] v, input logic [7:0] e);
        if4.mdata_in[0] = v[31:24];
        if4.mdata_in[1] = v[23:16];
        if4.mdata_in[2] = v[15:8];
        if4.mdata_in[3] = v[7:0];
        if4.edata_in    = e;
    endtask

    function automatic logic [31:0] out4();
        return {if4.mdata_out[0], if4.mdata_out[1], if4.mdata_out[2], if4.mdata_out[3]};
    endfunction

    task automatic send4(input logic [31:0] v, input logic [7:0] e);
        set4(v, e);
        if4.data_in_valid = 1'b1;
        tick();
        if4.data_in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge up to the first visible data_out_valid.
    task automatic await4(output int lat);
        lat = 1;
        while (!if4.data_out_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int sent;
        int got;
        int acc;

        blk[0] = 32'h03FB0001; ex[0] = 8'd10; lg[0] = 4'd2;
        blk[1] = 32'h00000000; ex[1] = 8'd11; lg[1] = 4'd0;
        blk[2] = 32'h01000000; ex[2] = 8'd12; lg[2] = 4'd0;
        blk[3] = 32'h80050000; ex[3] = 8'd13; lg[3] = 4'd7;
        blk[4] = 32'h7F810000; ex[4] = 8'd14; lg[4] = 4'd6;
        blk[5] = 32'h0000EF10; ex[5] = 8'd15; lg[5] = 4'd4;
        blk[6] = 32'h02FD0100; ex[6] = 8'd16; lg[6] = 4'd1;
        blk[7] = 32'h000000C0; ex[7] = 8'd17; lg[7] = 4'd6;

        rst = 1'b0;
        set4(32'h0, 8'h0);
        if4.data_in_valid  = 1'b0;
        if4.data_out_ready = 1'b0;
        if1.mdata_in[0]    = 8'h00;
        if1.edata_in       = 8'h00;
        if1.data_in_valid  = 1'b0;
        if1.data_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid4", {31'd0, if4.data_out_valid}, 32'd0);
        chk("rst_log2",   {28'd0, if4.log2_max_out}, 32'd0);
        chk("rst_edata",  {24'd0, if4.edata_out}, 32'd0);
        chk("rst_valid1", {31'd0, if1.data_out_valid}, 32'd0);

        // Single block, measure latency and contents.
        rst = 1'b1;
        if4.data_out_ready = 1'b1;
        tick();
        send4(blk[0], ex[0]);
        await4(lat);
        chk("first_latency", lat, 32'd3);
        chk("first_mdata", out4(), blk[0]);
        chk("first_edata", {24'd0, if4.edata_out}, {24'd0, ex[0]});
        chk("first_log2",  {28'd0, if4.log2_max_out}, {28'd0, lg[0]});
        tick();

        // Back-to-back stream under random backpressure.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            if (sent < 8) begin
                set4(blk[sent], ex[sent]);
                if4.data_in_valid = 1'b1;
            end else begin
                if4.data_in_valid = 1'b0;
            end
            if4.data_out_ready = 1'($urandom_range(0, 1));
            #1;
            if (if4.data_out_valid && if4.data_out_ready) begin
                chk("stream_edata", {24'd0, if4.edata_out}, {24'd0, ex[got]});
                chk("stream_mdata", out4(), blk[got]);
                chk("stream_log2",  {28'd0, if4.log2_max_out}, {28'd0, lg[got]});
                got++;
            end
            if (if4.data_in_valid && if4.data_in_ready) sent++;
            tick();
        end
        if4.data_in_valid = 1'b0;
        chk("stream_sent", sent, 32'd8);
        chk("stream_got",  got,  32'd8);

        // Output held off: three accepts fill the pipe, then the head must hold.
        if4.data_out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            set4(32'h01020304, 8'(30 + acc));
            if4.data_in_valid = 1'b1;
            #1;
            if (!if4.data_in_ready) break;
            acc++;
            tick();
        end
        if4.data_in_valid = 1'b0;
        chk("full_accepts", acc, 32'd3);
        tick();
        chk("hold_head_a", {23'd0, if4.data_out_valid, if4.edata_out}, {23'd0, 1'b1, 8'd30});
        tick();
        chk("hold_head_b", {23'd0, if4.data_out_valid, if4.edata_out}, {23'd0, 1'b1, 8'd30});
        if4.data_out_ready = 1'b1;
        #1;
        chk("drain_0", {23'd0, if4.data_out_valid, if4.edata_out}, {23'd0, 1'b1, 8'd30});
        tick();
        chk("drain_1", {23'd0, if4.data_out_valid, if4.edata_out}, {23'd0, 1'b1, 8'd31});
        tick();
        chk("drain_2", {23'd0, if4.data_out_valid, if4.edata_out}, {23'd0, 1'b1, 8'd32});
        tick();

        // Reset with two blocks in flight, then a fresh block.
        send4(32'h11223344, 8'd20);
        send4(32'h55667744, 8'd21);
        rst = 1'b0;
        tick();
        chk("flush_valid", {31'd0, if4.data_out_valid}, 32'd0);
        rst = 1'b1;
        send4(32'h40000000, 8'd22);
        await4(lat);
        chk("post_rst_latency", lat, 32'd3);
        chk("post_rst_log2",  {28'd0, if4.log2_max_out}, 32'd6);
        chk("post_rst_edata", {24'd0, if4.edata_out}, 32'd22);
        tick();

        // Single-element block: one stage of latency.
        if1.mdata_in[0]   = 8'hFE;
        if1.edata_in      = 8'd5;
        if1.data_in_valid = 1'b1;
        tick();
        if1.data_in_valid = 1'b0;
        chk("bs1_valid", {31'd0, if1.data_out_valid}, 32'd1);
        chk("bs1_log2",  {28'd0, if1.log2_max_out}, 32'd1);
        chk("bs1_mdata", {24'd0, if1.mdata_out[0]}, 32'hFE);
        chk("bs1_edata", {24'd0, if1.edata_out}, 32'd5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
